// File: rtl/bitsparse_pkg.sv
// Shared types for the bit-sparse value/place converters at the PE-array boundary.
// Both the forward and the inverse converter use the two-state sequencing enum.
package bitsparse_pkg;

   localparam int VALUE_W = 8;
   localparam int PLACE_W = 3;
   localparam int CNT_W   = 4;

   typedef logic [PLACE_W-1:0] place_t;
   typedef logic [VALUE_W-1:0] value_t;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } conv_state_e;

endpackage

// File: rtl/bit_places_to_value_place_accumulator.sv
// Merges one bit place per beat into a partial value, counting beats and
// detecting repeated places. Next-state values are exported for the output register.
module bit_places_to_value_place_accumulator #(
   parameter int WIDTH   = 8,
   parameter int PLACE_W = $clog2(WIDTH),
   parameter int CNT_W   = $clog2(WIDTH + 1)
) (
   input  logic               CLK,
   input  logic               RSTN,
   input  logic               i_beat,
   input  logic               i_zero,
   input  logic               i_clear,
   input  logic [PLACE_W-1:0] i_place,
   output logic [WIDTH-1:0]   o_acc_next,
   output logic [CNT_W-1:0]   o_cnt_next,
   output logic               o_dup_next
);

   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_dup;
   logic [WIDTH-1:0] w_mask;

   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      w_mask          = '0;
      w_mask[i_place] = 1'b1;
      o_acc_next      = r_acc;
      o_cnt_next      = r_cnt;
      o_dup_next      = r_dup;
      if (i_beat && !i_zero) begin
         o_acc_next = r_acc | w_mask;
         o_dup_next = r_dup | (|(r_acc & w_mask));
         // Once all places are taken the count pins at WIDTH
         o_cnt_next = (r_cnt == CNT_W'(WIDTH)) ? r_cnt : r_cnt + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_dup <= 1'b0;
      end else if (i_clear) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_dup <= 1'b0;
      end else if (i_beat) begin
         r_acc <= o_acc_next;
         r_cnt <= o_cnt_next;
         r_dup <= o_dup_next;
      end
   end

endmodule

// File: rtl/bit_places_to_value.sv
// Rebuilds dense values from sparse set-bit place streams, with valid/ready on
// both sides, a per-value place count, a duplicate flag and a sticky protocol error.
module bit_places_to_value #(
   parameter int WIDTH   = 8,
   parameter int PLACE_W = $clog2(WIDTH),
   parameter int CNT_W   = $clog2(WIDTH + 1)
) (
   input  logic               CLK,
   input  logic               RSTN,
   input  logic               InValid,
   output logic               InReady,
   input  logic [PLACE_W-1:0] BitPlace,
   input  logic               InLast,
   input  logic               InZero,
   output logic               OutValid,
   input  logic               OutReady,
   output logic [WIDTH-1:0]   OutValue,
   output logic [CNT_W-1:0]   PlaceCount,
   output logic               OutDup,
   output logic               ProtoErr
);

   import bitsparse_pkg::conv_state_e;
   import bitsparse_pkg::COLLECT;
   import bitsparse_pkg::HOLD;

   conv_state_e      r_state;
   logic [WIDTH-1:0] r_out_value;
   logic [CNT_W-1:0] r_out_cnt;
   logic             r_out_dup;
   logic             r_proto_err;

   logic             w_accept;
   logic             w_emit;
   logic [WIDTH-1:0] w_acc_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_dup_next;

   // Draining the held value and accepting a new beat share one cycle
   assign OutValid = (r_state == HOLD);
   assign InReady  = !OutValid || OutReady;
   assign w_accept = InValid && InReady;
   assign w_emit   = w_accept && InLast;

   bit_places_to_value_place_accumulator #(
      .WIDTH   (WIDTH),
      .PLACE_W (PLACE_W),
      .CNT_W   (CNT_W)
   ) u_acc (
      .CLK        (CLK),
      .RSTN       (RSTN),
      .i_beat     (w_accept),
      .i_zero     (InZero),
      .i_clear    (w_emit),
      .i_place    (BitPlace),
      .o_acc_next (w_acc_next),
      .o_cnt_next (w_cnt_next),
      .o_dup_next (w_dup_next)
   );

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state     <= COLLECT;
         r_out_value <= '0;
         r_out_cnt   <= '0;
         r_out_dup   <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_emit) begin
            r_state     <= HOLD;
            r_out_value <= w_acc_next;
            r_out_cnt   <= w_cnt_next;
            r_out_dup   <= w_dup_next;
         end else if (OutValid && OutReady) begin
            r_state <= COLLECT;
         end
         if (w_accept && InZero && !InLast)
            r_proto_err <= 1'b1;
      end
   end

   assign OutValue   = r_out_value;
   assign PlaceCount = r_out_cnt;
   assign OutDup     = r_out_dup;
   assign ProtoErr   = r_proto_err;

endmodule

// File: doc/bit_places_to_value.md
Name: bit_places_to_value

Overview:
- Inverse of the values-to-bit converter: rebuilds an 8-bit value from a stream of set-bit positions (BitPlace), one position per accepted beat.
- Sits at the output side of the bit-serial PE array. Partial results leave the array as sparse bit-place streams and are repacked into dense words for writeback.
- Valid/ready handshake on both sides.
- Also reports the number of places per value and flags any duplicate places.

Parameters:
- WIDTH, 8, width of the reconstructed value.
- PLACE_W, $clog2(WIDTH), width of BitPlace.
- CNT_W, $clog2(WIDTH+1), width of PlaceCount.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RSTN  input  1  reset, asynchronous, active-low.
- InValid  input  1  an input beat is presented.
- InReady  output  1  the block accepts the beat this cycle.
- BitPlace  input  PLACE_W  position of one set bit of the current value.
- InLast  input  1  the beat closes the current value.
- InZero  input  1  the value has no set bits; BitPlace is ignored; InLast must be 1.
- OutValid  output  1  a reconstructed value is presented.
- OutReady  input  1  downstream accepts the value.
- OutValue  output  WIDTH  reconstructed value.
- PlaceCount  output  CNT_W  number of non-zero beats merged into OutValue.
- OutDup  output  1  at least one BitPlace repeated within this value.
- ProtoErr  output  1  sticky flag; set by a beat with InZero=1 and InLast=0; cleared only by reset.

Behaviour:
- Reset (RSTN=0, asynchronous):
  - acc=0, cnt=0, dup=0, state=COLLECT.
  - OutValid=0, OutValue=0, PlaceCount=0, OutDup=0, ProtoErr=0.
- A beat is accepted when InValid && InReady.
- InReady is combinational: InReady = !OutValid || OutReady. The same-cycle drain-and-accept path has no bubble.
- State COLLECT, for each accepted beat:
  - If InZero=0:
    - mask = 1<<BitPlace.
    - dup_n = dup | |(acc & mask).
    - acc_n = acc | mask.
    - cnt_n = cnt+1, saturating at WIDTH.
  - If InZero=1: acc, cnt and dup are unchanged.
  - If InLast=1:
    - Next cycle OutValid=1, OutValue=acc_n, PlaceCount=cnt_n, OutDup=dup_n.
    - Accumulator state clears to 0. State becomes HOLD.
  - Latency: one cycle from the accepted last beat to OutValid.
- State HOLD:
  - OutValue, PlaceCount and OutDup stay stable while OutValid && !OutReady.
  - When OutReady=1:
    - If no last beat is accepted in the same cycle, OutValid drops next cycle and state returns to COLLECT.
    - Non-last beats accepted in the same cycle start the next value in the cleared accumulator.
    - A last beat accepted in the same cycle keeps OutValid high with the new value. This gives back-to-back single-beat values at full rate.
- Places may arrive in any order. Set bits are never checked against value range beyond PLACE_W (WIDTH is a power of two).
- InZero=1 with InLast=0: treated as a no-op beat and sets ProtoErr. The value continues collecting.
- Reset mid-value discards the partial accumulator. The next value starts clean.
- Maximum distinct places per value is WIDTH. Beats beyond WIDTH always raise OutDup; cnt saturates at WIDTH.

Decomposition:
- Shared package bitsparse_pkg holds:
  - localparams VALUE_W=8, PLACE_W=3, CNT_W=4.
  - typedef place_t of logic[PLACE_W-1:0].
  - typedef value_t of logic[VALUE_W-1:0].
  - enum conv_state_e {COLLECT, HOLD}. The forward converter uses the same enum.
- One natural sub-module: place_accumulator. It holds acc/cnt/dup and their next-state logic, with a clear input. The top keeps the handshake and output register.

Test Plan:
1. Beats BitPlace=0, then 1 (InLast=1), OutReady=1 -> one cycle later OutValue=0x03, PlaceCount=2, OutDup=0, OutValid high for exactly 1 cycle.
2. Beats 7,6,5,4,2,1,0 (last on 0) -> OutValue=0xF7, PlaceCount=7. Repeat in order 0,2,1,4,7,5,6 -> same result.
3. Single beat InZero=1, InLast=1 -> OutValue=0x00, PlaceCount=0. Then InZero=1, InLast=0 -> ProtoErr=1, held until RSTN.
4. Beats 3, 3 (last) -> OutValue=0x08, PlaceCount=2, OutDup=1. Next value of single place 5 -> 0x20, OutDup=0.
5. OutReady=0 for 3 cycles after value 0xF7 -> OutValid stays 1, OutValue stable, InReady=0, no beats lost. Release with a new last beat (place 4) in the same cycle -> next OutValue=0x10 with no bubble.
6. Place 5 accepted, RSTN pulsed low mid-cycle, then place 1 (last) -> OutValue=0x02, PlaceCount=1. All outputs read 0 while RSTN is low.
